// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the program loader: FSM states, word geometry
// and the byte-lane ordering used when assembling instruction words.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Byte 0 of the stream lands in the least-significant lane.
  localparam bit LANES_LITTLE_ENDIAN = 1'b1;

  function automatic int bytes_per_word(input int data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects a stream of bytes into DATA_SIZE-bit words; emits a registered
// word_valid pulse and the assembled word one cycle after the final byte.
module byte_packer
  import prog_loader_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 last_byte,
  output logic                 word_valid,
  output logic [DATA_SIZE-1:0] word
);

  localparam int BPW    = bytes_per_word(DATA_SIZE);
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LANE_W-1:0]    lane_reg;
  logic [DATA_SIZE-1:0] shift_reg;
  logic [DATA_SIZE-1:0] word_reg;
  logic                 word_valid_reg;
  logic [DATA_SIZE-1:0] assemble_next;

  assign last_byte = byte_valid && (lane_reg == LANE_W'(BPW - 1));

  // Each lane takes the incoming byte when the lane counter points at it,
  // so stale bytes from an abandoned word are always overwritten.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      localparam int SLOT = LANES_LITTLE_ENDIAN ? gi : (BPW - 1 - gi);
      assign assemble_next[8*gi +: 8] =
        (byte_valid && lane_reg == LANE_W'(SLOT)) ? byte_data : shift_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg       <= '0;
      shift_reg      <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= last_byte && !clear;
      if (clear) begin
        lane_reg  <= '0;
        shift_reg <= '0;
      end else if (byte_valid) begin
        shift_reg <= assemble_next;
        lane_reg  <= last_byte ? '0 : lane_reg + LANE_W'(1);
        if (last_byte) begin
          word_reg <= assemble_next;
        end
      end
    end
  end

  assign word_valid = word_valid_reg;
  assign word       = word_reg;

endmodule

// File: rtl/prog_loader.sv
// Load/run sequencer: streams a program into instruction memory with the core
// held in reset, releases it, then counts run cycles until halt or timeout.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_SIZE      = 10,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   word_count,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 imem_we,
  output logic [ADDR_SIZE-1:0] imem_waddr,
  output logic [DATA_SIZE-1:0] imem_wdata,
  input  logic                 halt,
  output logic                 core_reset_n,
  output logic                 core_clear,
  output logic                 run_done,
  output logic                 timeout,
  output logic [31:0]          cycles
);

  localparam logic [ADDR_SIZE:0] MAX_WORDS      = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] ONE_WORD       = (ADDR_SIZE + 1)'(1);
  localparam logic [31:0]        LAST_RUN_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  state_t               state_reg;
  logic                 s_ready_reg;
  logic                 core_reset_n_reg;
  logic                 core_clear_reg;
  logic                 run_done_reg;
  logic                 timeout_reg;
  logic [31:0]          cycles_reg;
  logic [ADDR_SIZE:0]   count_reg;
  logic [ADDR_SIZE:0]   word_idx_reg;
  logic [ADDR_SIZE-1:0] waddr_reg;

  logic [ADDR_SIZE:0]   count_sat;
  logic                 start_ok;
  logic                 byte_accept;
  logic                 last_byte;

  assign count_sat   = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign start_ok    = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign byte_accept = s_valid && s_ready_reg;

  byte_packer #(
    .DATA_SIZE (DATA_SIZE)
  ) u_packer (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (start_ok),
    .byte_valid (byte_accept),
    .byte_data  (s_data),
    .last_byte  (last_byte),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg        <= ST_IDLE;
      s_ready_reg      <= 1'b0;
      core_reset_n_reg <= 1'b0;
      core_clear_reg   <= 1'b1;
      run_done_reg     <= 1'b0;
      timeout_reg      <= 1'b0;
      cycles_reg       <= '0;
      count_reg        <= '0;
      word_idx_reg     <= '0;
      waddr_reg        <= '0;
    end else begin
      // The address is latched together with the word so it lines up with imem_we.
      if (last_byte) begin
        waddr_reg    <= word_idx_reg[ADDR_SIZE-1:0];
        word_idx_reg <= word_idx_reg + ONE_WORD;
      end
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            run_done_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            count_reg    <= count_sat;
            word_idx_reg <= '0;
            waddr_reg    <= '0;
            if (count_sat != '0) begin
              state_reg   <= ST_LOAD;
              s_ready_reg <= 1'b1;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end
        end
        ST_LOAD: begin
          // s_ready low inside LOAD marks the cycle carrying the final write.
          if (!s_ready_reg) begin
            state_reg <= ST_RELEASE;
          end else if (last_byte && word_idx_reg == count_reg - ONE_WORD) begin
            s_ready_reg <= 1'b0;
          end
        end
        ST_RELEASE: begin
          cycles_reg       <= '0;
          state_reg        <= ST_RUN;
          core_reset_n_reg <= 1'b1;
          core_clear_reg   <= 1'b0;
        end
        ST_RUN: begin
          cycles_reg <= cycles_reg + 32'd1;
          if (halt) begin
            state_reg        <= ST_DONE;
            run_done_reg     <= 1'b1;
            core_reset_n_reg <= 1'b0;
            core_clear_reg   <= 1'b1;
          end else if (cycles_reg == LAST_RUN_CYCLE) begin
            state_reg        <= ST_DONE;
            timeout_reg      <= 1'b1;
            core_reset_n_reg <= 1'b0;
            core_clear_reg   <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_reg;
  assign imem_waddr   = waddr_reg;
  assign core_reset_n = core_reset_n_reg;
  assign core_clear   = core_clear_reg;
  assign run_done     = run_done_reg;
  assign timeout      = timeout_reg;
  assign cycles       = cycles_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized load/run sessions compared
// against a word-level model of the expected writes and run outcome.
module tb_prog_loader;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int TO   = 8;
  localparam int MAXW = 1 << AW;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          halt = 1'b0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic          core_reset_n;
  logic          core_clear;
  logic          run_done;
  logic          timeout;
  logic [31:0]   cycles;

  int errors = 0;
  int checks = 0;

  logic [AW+DW-1:0] wr_q[$];
  int               bad_rst = 0;
  bit               in_load = 1'b0;

  prog_loader #(
    .ADDR_SIZE      (AW),
    .DATA_SIZE      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .start        (start),
    .word_count   (word_count),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .halt         (halt),
    .core_reset_n (core_reset_n),
    .core_clear   (core_clear),
    .run_done     (run_done),
    .timeout      (timeout),
    .cycles       (cycles)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (imem_we) wr_q.push_back({imem_waddr, imem_wdata});
    if (in_load && core_reset_n) bad_rst++;
  end

  task automatic start_session(input int wc);
    @(posedge CLK); #1;
    word_count = (AW + 1)'(wc);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic drive_bytes(input logic [7:0] bytes[$], input int mode, output int n);
    int idx;
    bit v, acc;
    idx = 0;
    n = 0;
    while (idx < bytes.size() && n < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = v ? bytes[idx] : 8'($urandom);
      acc = v && s_ready;
      @(posedge CLK); #1;
      n++;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    checks++;
    if (idx != bytes.size()) begin
      errors++;
      $display("FAIL drive_bytes: sent %0d bytes, required %0d", idx, bytes.size());
    end
  endtask

  task automatic load_and_run(input string name, input int wc, input logic [DW-1:0] words[$],
                              input int mode, input int halt_at, input int start_in_run);
    logic [7:0]       bytes[$];
    logic [AW+DW-1:0] exp_q[$];
    int n, m, k, bad_at;
    logic exp_done, exp_to;
    logic [31:0] exp_cyc;

    // Model: word i lives at address i, byte k of it is bits [8k+7:8k].
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back({AW'(i), words[i]});
      for (int b = 0; b < DW / 8; b++) bytes.push_back(words[i][8*b +: 8]);
    end
    if (halt_at >= 1 && halt_at <= TO) begin
      exp_done = 1'b1; exp_to = 1'b0; exp_cyc = 32'(halt_at);
    end else begin
      exp_done = 1'b0; exp_to = 1'b1; exp_cyc = 32'(TO);
    end

    wr_q.delete();
    bad_rst = 0;
    in_load = 1'b1;
    halt = 1'b1;  // must be ignored until the core runs
    start_session(wc);

    if (words.size() > 0) begin
      drive_bytes(bytes, mode, n);
      if (mode == 0) begin
        checks++;
        if (n != bytes.size()) begin
          errors++;
          $display("FAIL %s gapless: cycles=%0d required %0d", name, n, bytes.size());
        end
      end
      checks++;
      if (imem_we !== 1'b1 || {imem_waddr, imem_wdata} !== exp_q[exp_q.size()-1]) begin
        errors++;
        $display("FAIL %s write_latency: we=%b addr/data=%h required we=1 %h",
                 name, imem_we, {imem_waddr, imem_wdata}, exp_q[exp_q.size()-1]);
      end
      s_valid = 1'b1;
      s_data  = 8'hAA;
      checks++;
      if (s_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_drop: s_ready=%b required 0", name, s_ready);
      end
    end

    m = 0;
    while (core_reset_n !== 1'b1 && m < 20) begin
      @(posedge CLK); #1;
      m++;
    end
    s_valid = 1'b0;
    in_load = 1'b0;
    checks++;
    if (m != ((words.size() > 0) ? 2 : 1)) begin
      errors++;
      $display("FAIL %s release_latency: edges=%0d required %0d", name, m,
               (words.size() > 0) ? 2 : 1);
    end

    bad_at = -1;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      if (bad_at < 0 && wr_q[i] !== exp_q[i]) bad_at = i;
    checks++;
    if (wr_q.size() != exp_q.size() || bad_at >= 0) begin
      errors++;
      $display("FAIL %s imem_writes: count=%0d first_bad=%0d required count=%0d all matching",
               name, wr_q.size(), bad_at, exp_q.size());
    end
    checks++;
    if (bad_rst != 0) begin
      errors++;
      $display("FAIL %s core_held: core_reset_n high for %0d load cycles, required 0", name, bad_rst);
    end

    k = 1;
    while (k <= 40) begin
      halt       = (k == halt_at);
      start      = (k == start_in_run);
      word_count = '0;
      @(posedge CLK); #1;
      start = 1'b0;
      if (core_reset_n !== 1'b1) break;
      k++;
    end
    halt = 1'b0;
    checks++;
    if (k != int'(exp_cyc)) begin
      errors++;
      $display("FAIL %s run_length: run cycles=%0d required %0d", name, k, exp_cyc);
    end
    checks++;
    if ({run_done, timeout, cycles, core_clear} !== {exp_done, exp_to, exp_cyc, 1'b1}) begin
      errors++;
      $display("FAIL %s outcome: done=%b timeout=%b cycles=%0d clear=%b required %b %b %0d 1",
               name, run_done, timeout, cycles, core_clear, exp_done, exp_to, exp_cyc);
    end

    halt = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    halt = 1'b0;
    checks++;
    if ({run_done, timeout, cycles, core_reset_n, core_clear} !== {exp_done, exp_to, exp_cyc, 2'b01}) begin
      errors++;
      $display("FAIL %s done_frozen: done=%b timeout=%b cycles=%0d rst_n=%b clear=%b required %b %b %0d 0 1",
               name, run_done, timeout, cycles, core_reset_n, core_clear, exp_done, exp_to, exp_cyc);
    end
    $display("session %s wc=%0d writes=%0d cycles=%0d run_done=%b timeout=%b",
             name, wc, wr_q.size(), cycles, run_done, timeout);
  endtask

  task automatic test_reset();
    logic [73:0] got, want;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    got  = {s_ready, imem_we, imem_waddr, imem_wdata, core_reset_n, core_clear, run_done, timeout, cycles};
    want = {1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required %h", got, want);
    end
    RESET_N = 1'b1;
    $display("reset released");
  endtask

  task automatic test_program_load();
    logic [DW-1:0] w[$];
    w = '{32'h0000_0013, 32'h0010_0093, 32'h0000_0073};
    load_and_run("program", 3, w, 0, 5, 0);
  endtask

  task automatic test_timeout();
    logic [DW-1:0] w[$];
    w = '{DW'($urandom), DW'($urandom)};
    load_and_run("timeout", 2, w, 2, 0, 0);
    w = '{DW'($urandom)};
    load_and_run("halt_timeout_tie", 1, w, 0, TO, 0);
  endtask

  task automatic test_valid_toggle();
    logic [DW-1:0] w[$];
    w = '{DW'($urandom), DW'($urandom)};
    load_and_run("valid_toggle", 2, w, 1, $urandom_range(1, TO - 1), 0);
  endtask

  task automatic test_reset_mid();
    logic [7:0]    b[$];
    logic [DW-1:0] w[$];
    int n;
    start_session(2);
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    drive_bytes(b, 0, n);
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({s_ready, imem_we, core_reset_n, core_clear} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_async: ready/we/rst_n/clear=%b required 0001",
               {s_ready, imem_we, core_reset_n, core_clear});
    end
    #3;
    RESET_N = 1'b1;
    $display("reset pulsed mid-load after %0d bytes", b.size());
    w = '{DW'($urandom)};
    load_and_run("after_reset", 1, w, 0, 3, 0);
  endtask

  task automatic test_skip_load();
    logic [DW-1:0] w[$];
    load_and_run("skip_load", 0, w, 0, 6, 3);
  endtask

  task automatic test_saturate();
    logic [DW-1:0] w[$];
    for (int i = 0; i < MAXW; i++) w.push_back(DW'($urandom));
    load_and_run("saturate", MAXW + 4, w, 2, 2, 0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[$];
    int wc;
    for (int s = 0; s < 4; s++) begin
      w.delete();
      wc = $urandom_range(1, 5);
      for (int i = 0; i < wc; i++) w.push_back(DW'($urandom));
      load_and_run($sformatf("b2b%0d", s), wc, w, $urandom_range(0, 2),
                   $urandom_range(1, TO + 2), $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    test_program_load();
    test_timeout();
    test_valid_toggle();
    test_reset_mid();
    test_skip_load();
    test_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
